// File: rtl/msg_sender_pkg.sv
// -----------------------------------------------------------------------------
// msg_sender_pkg
// Shared types and constants for the msg_sender block.
//   state_t   : sequencer states (SUFFIX exists only with MSG_SENDER_CRLF_EN)
//   ASCII_CR  : carriage return appended after each pass (CRLF build)
//   ASCII_LF  : line feed appended after each pass (CRLF build)
//   min_len() : clamp helper used when latching the message length
// Optional feature macro: MSG_SENDER_CRLF_EN
// -----------------------------------------------------------------------------
package msg_sender_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
`ifdef MSG_SENDER_CRLF_EN
    ,
    SUFFIX
`endif
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic int unsigned min_len(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/msg_sender_if.sv
// -----------------------------------------------------------------------------
// msg_sender_if
// Character stream from msg_sender to the UART transmitter.
//   tx_data  : character offered to the sink
//   tx_valid : tx_data is valid
//   tx_ready : sink accepts tx_data this cycle
// Modports: master (sender side), slave (UART side).
// -----------------------------------------------------------------------------
interface msg_sender_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/msg_sender_rise_edge_det.sv
// -----------------------------------------------------------------------------
// rise_edge_det
// Registered rising-edge detector.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (history cleared to 0)
//   d_i    : level input
//   rise_o : high while d_i=1 and the previous sampled value was 0
// -----------------------------------------------------------------------------
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= d_i;
    end
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/msg_sender.sv
// -----------------------------------------------------------------------------
// msg_sender
// Sends a runtime-loaded message (up to MSG_LEN characters) to a UART
// transmitter over a valid/ready stream. Single-shot or repeat mode, optional
// idle gap after every accepted character, and abort.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   trigger_i    : start request (rising edge only, in IDLE)
//   repeat_en_i  : resend continuously, checked at each pass boundary
//   abort_i      : stop and return to IDLE on the next edge
//   cfg_len_i    : message length, clamped to MSG_LEN and latched at start
//   wr_en_i, wr_addr_i, wr_data_i : buffer write port (IDLE only)
//   tx           : msg_sender_if.master stream towards the UART
//   busy_o       : not IDLE
//   done_o       : high on the handshake that completes a pass
//   byte_idx_o   : index of the character currently offered
// Optional feature macro: MSG_SENDER_CRLF_EN (appends CR, LF to every pass).
// -----------------------------------------------------------------------------
module msg_sender
  import msg_sender_pkg::*;
#(
  parameter int MSG_LEN    = 16,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 0,
  parameter int IDX_W      = $clog2(MSG_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                trigger_i,
  input  logic                repeat_en_i,
  input  logic                abort_i,
  input  logic [IDX_W-1:0]    cfg_len_i,
  input  logic                wr_en_i,
  input  logic [IDX_W-1:0]    wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  msg_sender_if.master        tx,
  output logic                busy_o,
  output logic                done_o,
  output logic [IDX_W-1:0]    byte_idx_o
);

  // The internal index carries one extra bit so the CR/LF positions (L, L+1)
  // always fit even when L == MSG_LEN.
  localparam int CW = IDX_W + 1;
`ifdef MSG_SENDER_CRLF_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GCW-1:0] GAP_LOAD = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t              state_q, state_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]    len_q, len_d;
  logic [GCW-1:0]      gap_q, gap_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                done_d;

  logic [DATA_W-1:0]   buf_q [MSG_LEN];
  logic [MSG_LEN-1:0]  wr_sel;

  logic                trig_rise;
  logic [IDX_W-1:0]    len_eff;
  logic [CW-1:0]       last_idx;
  logic [CW-1:0]       seq_idx;
  logic [CW-1:0]       rd_idx;
  logic [DATA_W-1:0]   rd_char;
  state_t              present_state;
  logic                handshake;

  rise_edge_det u_trig (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (trigger_i),
    .rise_o (trig_rise)
  );

  assign len_eff   = IDX_W'(min_len(32'(cfg_len_i), 32'(MSG_LEN)));
  assign last_idx  = CW'(len_q) + CW'(EXTRA) - CW'(1);
  assign handshake = tx_valid_q & tx.tx_ready;

  // ---------------------------------------------------------------------------
  // Message buffer: writes only land while IDLE; out-of-range addresses match
  // no entry and are dropped.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < MSG_LEN; gi++) begin : g_wr_sel
    assign wr_sel[gi] = wr_en_i && (state_q == IDLE) && (wr_addr_i == IDX_W'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MSG_LEN; i++) begin
        if (wr_sel[i]) begin
          buf_q[i] <= wr_data_i;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Index of the character to be presented next. In GAP the index was already
  // advanced on the handshake, so it is used as is.
  // ---------------------------------------------------------------------------
  always_comb begin
    seq_idx = (idx_q == last_idx) ? '0 : idx_q + CW'(1);
    if (state_q == GAP) begin
      rd_idx = idx_q;
    end else if (state_q == IDLE) begin
      rd_idx = '0;
    end else begin
      rd_idx = seq_idx;
    end
  end

  always_comb begin
`ifdef MSG_SENDER_CRLF_EN
    present_state = (rd_idx >= CW'(len_q)) ? SUFFIX : SEND;
`else
    present_state = SEND;
`endif
  end

  always_comb begin
    rd_char = '0;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (rd_idx == CW'(i)) begin
        rd_char = buf_q[i];
      end
    end
`ifdef MSG_SENDER_CRLF_EN
    // Suffix positions override whatever the buffer holds at index L / L+1.
    if (rd_idx == CW'(len_q)) begin
      rd_char = DATA_W'(ASCII_CR);
    end else if (rd_idx == CW'(len_q) + CW'(1)) begin
      rd_char = DATA_W'(ASCII_LF);
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Sequencer next-state / outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    gap_d      = gap_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (trig_rise && (len_eff != '0)) begin
          len_d      = len_eff;
          idx_d      = '0;
          state_d    = SEND;
          tx_valid_d = 1'b1;
          tx_data_d  = rd_char;
        end
      end
`ifdef MSG_SENDER_CRLF_EN
      SEND, SUFFIX: begin
`else
      SEND: begin
`endif
        if (handshake) begin
          done_d = (idx_q == last_idx);
          if ((idx_q != last_idx) || repeat_en_i) begin
            idx_d = seq_idx;
            if (GAP_CYCLES > 0) begin
              state_d    = GAP;
              tx_valid_d = 1'b0;
              gap_d      = GAP_LOAD;
            end else begin
              state_d   = present_state;
              tx_data_d = rd_char;
            end
          end else begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
            idx_d      = '0;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d    = present_state;
          tx_valid_d = 1'b1;
          tx_data_d  = rd_char;
        end else begin
          gap_d = gap_q - GCW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = '0;
        idx_d      = '0;
      end
    endcase

    // Abort wins over a same-cycle handshake; that character still counts as
    // delivered on the sink side, but the pass is not reported as done.
    if (abort_i && (state_q != IDLE)) begin
      state_d    = IDLE;
      tx_valid_d = 1'b0;
      tx_data_d  = '0;
      idx_d      = '0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      gap_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_d;
  assign byte_idx_o  = idx_q[IDX_W-1:0];

endmodule

// File: tb/tb_msg_sender.sv
// -----------------------------------------------------------------------------
// tb_msg_sender
// Directed bench for msg_sender. Two instances share the write port and most
// controls: dut (GAP_CYCLES=0) and dut_g (GAP_CYCLES=3), each with its own
// trigger. Expected characters come from a local copy of the written buffer.
// -----------------------------------------------------------------------------
module tb_msg_sender;

`ifdef MSG_SENDER_CRLF_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trig, trig_g, rep, abrt, wr_en, rdy;
  logic [4:0] cfg_len, wr_addr;
  logic [7:0] wr_data;
  logic       busy, done, busy_g, done_g;
  logic [4:0] bidx, bidx_g;

  logic [7:0] msg_mem [16];
  int         n_chk  = 0;
  int         n_fail = 0;

  msg_sender_if #(.DATA_W(8)) bus ();
  msg_sender_if #(.DATA_W(8)) bus_g ();

  assign bus.tx_ready   = rdy;
  assign bus_g.tx_ready = rdy;

  msg_sender #(.MSG_LEN(16), .DATA_W(8), .GAP_CYCLES(0)) dut (
    .clk (clk), .rst_n (rst_n), .trigger_i (trig), .repeat_en_i (rep),
    .abort_i (abrt), .cfg_len_i (cfg_len), .wr_en_i (wr_en),
    .wr_addr_i (wr_addr), .wr_data_i (wr_data), .tx (bus.master),
    .busy_o (busy), .done_o (done), .byte_idx_o (bidx)
  );

  msg_sender #(.MSG_LEN(16), .DATA_W(8), .GAP_CYCLES(3)) dut_g (
    .clk (clk), .rst_n (rst_n), .trigger_i (trig_g), .repeat_en_i (rep),
    .abort_i (abrt), .cfg_len_i (cfg_len), .wr_en_i (wr_en),
    .wr_addr_i (wr_addr), .wr_data_i (wr_data), .tx (bus_g.master),
    .busy_o (busy_g), .done_o (done_g), .byte_idx_o (bidx_g)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = 5'(a);
    wr_data = d;
    cyc();
    wr_en   = 1'b0;
    msg_mem[a] = d;
  endtask

  // Leaves the bench 2 time units after the edge that starts the pass.
  task automatic pulse_trig();
    trig = 1'b1;
    cyc();
    trig = 1'b0;
    #1;
  endtask

  function automatic logic [7:0] exp_char(input int k, input int len);
    if (k < len) return msg_mem[k];
    else if (k == len) return 8'h0D;
    else return 8'h0A;
  endfunction

  // One full pass on dut with tx_ready held high.
  task automatic expect_pass(input string tag, input int len);
    int p;
    p = len + EXTRA;
    for (int k = 0; k < p; k++) begin
      chk({tag, "_valid"}, 32'(bus.tx_valid), 32'd1);
      chk({tag, "_data"},  32'(bus.tx_data), 32'(exp_char(k, len)));
      chk({tag, "_idx"},   32'(bidx), 32'(k));
      chk({tag, "_done"},  32'(done), 32'(k == p - 1));
      $display("%s char %0d data=%02h done=%0b", tag, k, bus.tx_data, done);
      cyc();
    end
  endtask

  initial begin
    int k, c, p;
    logic [3:0] pat;

    for (int i = 0; i < 16; i++) msg_mem[i] = 8'h00;
    rst_n = 1'b0; trig = 1'b0; trig_g = 1'b0; rep = 1'b0; abrt = 1'b0;
    wr_en = 1'b0; rdy = 1'b1; cfg_len = '0; wr_addr = '0; wr_data = '0;

    // Reset values
    cyc(); cyc();
    chk("rst_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_data",  32'(bus.tx_data), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_idx",   32'(bidx), 32'd0);
    rst_n = 1'b1;
    cyc();

    // T1: "2024311668", back-to-back
    begin
      logic [7:0] id [10];
      id = '{8'h32, 8'h30, 8'h32, 8'h34, 8'h33, 8'h31, 8'h31, 8'h36, 8'h36, 8'h38};
      for (int i = 0; i < 10; i++) wr(i, id[i]);
    end
    cfg_len = 5'd10;
    pulse_trig();
    chk("t1_busy", 32'(busy), 32'd1);
    expect_pass("t1", 10);
    chk("t1_end_busy",  32'(busy), 32'd0);
    chk("t1_end_valid", 32'(bus.tx_valid), 32'd0);
    chk("t1_end_done",  32'(done), 32'd0);

    // T2: tx_ready pattern 1-0-0-1
    pat = 4'b1001;
    p = 10 + EXTRA;
    pulse_trig();
    k = 0; c = 0;
    while (k < p && c < 100) begin
      rdy = pat[c % 4];
      #1;
      chk("t2_valid", 32'(bus.tx_valid), 32'd1);
      chk("t2_data",  32'(bus.tx_data), 32'(exp_char(k, 10)));
      chk("t2_idx",   32'(bidx), 32'(k));
      chk("t2_done",  32'(done), 32'(rdy && (k == p - 1)));
      $display("t2 cycle %0d ready=%0b data=%02h", c, rdy, bus.tx_data);
      if (rdy) k++;
      c++;
      cyc();
    end
    rdy = 1'b1;
    #1;
    chk("t2_count", 32'(k), 32'(p));
    chk("t2_end_busy", 32'(busy), 32'd0);

    // T3: GAP_CYCLES=3, L=4 on dut_g
    cfg_len = 5'd4;
    p = 4 + EXTRA;
    trig_g = 1'b1; cyc(); trig_g = 1'b0; #1;
    for (int j = 0; j < p; j++) begin
      chk("t3_valid", 32'(bus_g.tx_valid), 32'd1);
      chk("t3_data",  32'(bus_g.tx_data), 32'(exp_char(j, 4)));
      chk("t3_idx",   32'(bidx_g), 32'(j));
      chk("t3_done",  32'(done_g), 32'(j == p - 1));
      $display("t3 char %0d data=%02h", j, bus_g.tx_data);
      cyc();
      if (j < p - 1) begin
        for (int g = 0; g < 3; g++) begin
          chk("t3_gap_valid", 32'(bus_g.tx_valid), 32'd0);
          chk("t3_gap_busy",  32'(busy_g), 32'd1);
          cyc();
        end
      end
    end
    chk("t3_end_busy", 32'(busy_g), 32'd0);

    // T4: repeat "ABC", abort during second pass
    wr(0, 8'h41); wr(1, 8'h42); wr(2, 8'h43);
    cfg_len = 5'd3;
    rep = 1'b1;
    pulse_trig();
    expect_pass("t4p1", 3);
    chk("t4_wrap_data", 32'(bus.tx_data), 32'h41);
    chk("t4_wrap_idx",  32'(bidx), 32'd0);
    chk("t4_wrap_done", 32'(done), 32'd0);
    cyc();
    abrt = 1'b1;
    #1;
    chk("t4_abort_data", 32'(bus.tx_data), 32'h42);
    chk("t4_abort_done", 32'(done), 32'd0);
    $display("t4 abort with data=%02h", bus.tx_data);
    cyc();
    abrt = 1'b0; rep = 1'b0;
    #1;
    chk("t4_post_busy",  32'(busy), 32'd0);
    chk("t4_post_valid", 32'(bus.tx_valid), 32'd0);
    chk("t4_post_idx",   32'(bidx), 32'd0);
    chk("t4_post_done",  32'(done), 32'd0);

    // T5a: cfg_len=0 ignored
    cfg_len = 5'd0;
    pulse_trig();
    for (int j = 0; j < 3; j++) begin
      chk("t5_len0_busy",  32'(busy), 32'd0);
      chk("t5_len0_valid", 32'(bus.tx_valid), 32'd0);
      cyc();
    end
    $display("t5 cfg_len=0 trigger ignored");

    // T5b: cfg_len=MSG_LEN+5 clamps; trigger edge while busy ignored
    for (int i = 0; i < 16; i++) wr(i, 8'(8'h61 + i));
    cfg_len = 5'd21;
    p = 16 + EXTRA;
    pulse_trig();
    for (int j = 0; j < p; j++) begin
      if (j == 5) trig = 1'b1;
      if (j == 8) trig = 1'b0;
      #1;
      chk("t5_valid", 32'(bus.tx_valid), 32'd1);
      chk("t5_data",  32'(bus.tx_data), 32'(exp_char(j, 16)));
      chk("t5_idx",   32'(bidx), 32'(j));
      chk("t5_done",  32'(done), 32'(j == p - 1));
      $display("t5 char %0d data=%02h", j, bus.tx_data);
      cyc();
    end
    for (int j = 0; j < 2; j++) begin
      chk("t5_end_busy", 32'(busy), 32'd0);
      cyc();
    end

    // T6: "OK", then async reset mid-pass
    wr(0, 8'h4F); wr(1, 8'h4B);
    cfg_len = 5'd2;
    pulse_trig();
    expect_pass("t6", 2);
    chk("t6_end_busy", 32'(busy), 32'd0);
    pulse_trig();
    chk("t6_r_data", 32'(bus.tx_data), 32'h4F);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.tx_valid), 32'd0);
    chk("t6_rst_data",  32'(bus.tx_data), 32'd0);
    chk("t6_rst_busy",  32'(busy), 32'd0);
    chk("t6_rst_idx",   32'(bidx), 32'd0);
    chk("t6_rst_done",  32'(done), 32'd0);
    $display("t6 async reset mid-pass");
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) msg_mem[i] = 8'h00;
    cyc();
    chk("t6_idle_busy", 32'(busy), 32'd0);
    // Buffer was cleared by reset: the first character reads back as zero.
    pulse_trig();
    chk("t6_clr_valid", 32'(bus.tx_valid), 32'd1);
    chk("t6_clr_data",  32'(bus.tx_data), 32'd0);
    abrt = 1'b1;
    cyc();
    abrt = 1'b0;
    #1;
    chk("t6_clr_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
